// File: rtl/dpu_cmd_arbiter.sv
// Round-robin arbiter sharing the single dpu_top PIO command port among N_REQ requesters.
// Supports burst locking, routes each read response to its owner, and bounds read waits with a timeout.
module dpu_cmd_arbiter #(
  parameter int         N_REQ       = 3,
  parameter int         ADDR_BITS   = 24,
  parameter logic [2:0] RD_TYPE     = 3'd4,
  parameter int         RSP_TIMEOUT = 1024
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*3-1:0]         req_type,
  input  logic [N_REQ*ADDR_BITS-1:0] req_addr,
  input  logic [N_REQ*8-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           req_rsp_valid,
  output logic [7:0]                 req_rsp_data,
  output logic                       req_rsp_err,
  output logic                       core_cmd_valid,
  input  logic                       core_cmd_ready,
  output logic [2:0]                 core_cmd_type,
  output logic [ADDR_BITS-1:0]       core_cmd_addr,
  output logic [7:0]                 core_cmd_data,
  input  logic                       core_rsp_valid,
  input  logic [7:0]                 core_rsp_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       arb_busy,
  output logic                       timeout_err,
  input  logic                       clear_err
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(RSP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    LOCKED   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_err_q, timeout_err_d;

  logic [2:0]           type_arr [N_REQ];
  logic [ADDR_BITS-1:0] addr_arr [N_REQ];
  logic [7:0]           data_arr [N_REQ];

  logic          arb_found;
  logic [GW-1:0] arb_pick;
  logic [GW-1:0] cand;
  logic          rsp_done;
  logic          set_err;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign type_arr[g] = req_type[3*g +: 3];
    assign addr_arr[g] = req_addr[ADDR_BITS*g +: ADDR_BITS];
    assign data_arr[g] = req_data[8*g +: 8];
  end

  // Owner's command fields follow the registered grant, so they stay stable while stalled.
  assign core_cmd_type = type_arr[grant_q];
  assign core_cmd_addr = addr_arr[grant_q];
  assign core_cmd_data = data_arr[grant_q];

  assign grant_id      = grant_q;
  assign arb_busy      = (state_q != IDLE);
  assign req_rsp_valid = rsp_valid_q;
  assign req_rsp_data  = rsp_data_q;
  assign req_rsp_err   = rsp_err_q;
  assign timeout_err   = timeout_err_q;

  // Round-robin search starting just above the previous winner, wrapping at N_REQ-1.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    cand      = last_grant_q;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == GW'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_pick  = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    rsp_valid_d    = '0;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = 1'b0;
    rsp_done       = 1'b0;
    set_err        = 1'b0;
    req_ready      = '0;
    core_cmd_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d      = arb_pick;
          last_grant_d = arb_pick;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        core_cmd_valid     = req_valid[grant_q];
        req_ready[grant_q] = core_cmd_ready;
        if (!req_valid[grant_q]) begin
          state_d = IDLE;
        end else if (core_cmd_ready) begin
          if (core_cmd_type == RD_TYPE) begin
            state_d = WAIT_RSP;
            cnt_d   = '0;
          end else if (req_lock[grant_q]) begin
            state_d = LOCKED;
          end else begin
            state_d = IDLE;
          end
        end
      end

      WAIT_RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (core_rsp_valid) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_data_d           = core_rsp_data;
          rsp_done             = 1'b1;
        end else if (cnt_d == CW'(RSP_TIMEOUT - 1)) begin
          // Synthesised error response so the owner is never left hanging.
          rsp_valid_d[grant_q] = 1'b1;
          rsp_data_d           = 8'hEE;
          rsp_err_d            = 1'b1;
          set_err              = 1'b1;
          rsp_done             = 1'b1;
        end
        if (rsp_done) begin
          state_d = req_lock[grant_q] ? LOCKED : IDLE;
        end
      end

      LOCKED: begin
        if (req_valid[grant_q]) begin
          state_d = ISSUE;
        end else if (!req_lock[grant_q]) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    timeout_err_d = set_err | (timeout_err_q & ~clear_err);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= GW'(N_REQ - 1);
      cnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_dpu_cmd_arbiter.sv
// Directed bench for dpu_cmd_arbiter: table of per-cycle arbitration vectors plus
// hand-written read, burst-lock, timeout, stall and reset sequences.
module tb_dpu_cmd_arbiter;

  localparam int N_REQ       = 3;
  localparam int ADDR_BITS   = 24;
  localparam int RSP_TIMEOUT = 1024;

  logic                       aclk;
  logic                       aresetn;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ*3-1:0]         req_type;
  logic [N_REQ*ADDR_BITS-1:0] req_addr;
  logic [N_REQ*8-1:0]         req_data;
  logic [N_REQ-1:0]           req_lock;
  logic [N_REQ-1:0]           req_rsp_valid;
  logic [7:0]                 req_rsp_data;
  logic                       req_rsp_err;
  logic                       core_cmd_valid;
  logic                       core_cmd_ready;
  logic [2:0]                 core_cmd_type;
  logic [ADDR_BITS-1:0]       core_cmd_addr;
  logic [7:0]                 core_cmd_data;
  logic                       core_rsp_valid;
  logic [7:0]                 core_rsp_data;
  logic [1:0]                 grant_id;
  logic                       arb_busy;
  logic                       timeout_err;
  logic                       clear_err;

  dpu_cmd_arbiter #(
    .N_REQ      (N_REQ),
    .ADDR_BITS  (ADDR_BITS),
    .RD_TYPE    (3'd4),
    .RSP_TIMEOUT(RSP_TIMEOUT)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_type      (req_type),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_lock      (req_lock),
    .req_rsp_valid (req_rsp_valid),
    .req_rsp_data  (req_rsp_data),
    .req_rsp_err   (req_rsp_err),
    .core_cmd_valid(core_cmd_valid),
    .core_cmd_ready(core_cmd_ready),
    .core_cmd_type (core_cmd_type),
    .core_cmd_addr (core_cmd_addr),
    .core_cmd_data (core_cmd_data),
    .core_rsp_valid(core_rsp_valid),
    .core_rsp_data (core_rsp_data),
    .grant_id      (grant_id),
    .arb_busy      (arb_busy),
    .timeout_err   (timeout_err),
    .clear_err     (clear_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  valid;
    logic        rdy;
    logic        exp_cvalid;
    logic [2:0]  exp_rready;
    logic [1:0]  exp_gid;
    logic        exp_busy;
    logic [23:0] exp_addr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, hs1, c, k;

    aresetn        = 1'b0;
    req_valid      = '0;
    req_type       = {3'd1, 3'd1, 3'd1};
    req_addr       = {24'h000220, 24'h000123, 24'h000010};
    req_data       = {8'hA2, 8'hA1, 8'hA0};
    req_lock       = '0;
    core_cmd_ready = 1'b0;
    core_rsp_valid = 1'b0;
    core_rsp_data  = 8'h00;
    clear_err      = 1'b0;

    vecs[0]  = '{3'b101, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 24'h000010};
    vecs[1]  = '{3'b101, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1, 24'h000010};
    vecs[2]  = '{3'b100, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 24'h000010};
    vecs[3]  = '{3'b100, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1, 24'h000220};
    vecs[4]  = '{3'b011, 1'b1, 1'b0, 3'b000, 2'd2, 1'b0, 24'h000220};
    vecs[5]  = '{3'b011, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1, 24'h000010};
    vecs[6]  = '{3'b010, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 24'h000010};
    vecs[7]  = '{3'b010, 1'b0, 1'b1, 3'b000, 2'd1, 1'b1, 24'h000123};
    vecs[8]  = '{3'b010, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1, 24'h000123};
    vecs[9]  = '{3'b100, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 24'h000123};
    vecs[10] = '{3'b000, 1'b0, 1'b0, 3'b000, 2'd2, 1'b1, 24'h000220};
    vecs[11] = '{3'b000, 1'b0, 1'b0, 3'b000, 2'd2, 1'b0, 24'h000220};

    // Reset state
    tick();
    tick();
    req_valid = 3'b111;
    settle();
    chk("reset_ctrl", {core_cmd_valid, req_ready, req_rsp_valid, req_rsp_err, timeout_err, arb_busy},
        {1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0});
    chk("reset_gid_data", {grant_id, req_rsp_data}, {2'd0, 8'h00});
    tick();
    req_valid = '0;
    aresetn   = 1'b1;

    // Arbitration table
    for (int i = 0; i < 12; i++) begin
      req_valid      = vecs[i].valid;
      core_cmd_ready = vecs[i].rdy;
      settle();
      chk($sformatf("arb_vec%0d", i),
          {core_cmd_valid, req_ready, grant_id, arb_busy, core_cmd_addr},
          {vecs[i].exp_cvalid, vecs[i].exp_rready, vecs[i].exp_gid, vecs[i].exp_busy, vecs[i].exp_addr});
      tick();
    end

    // Read from requester 1, core answers 7 cycles after the handshake
    req_type       = {3'd1, 3'd4, 3'd1};
    req_valid      = 3'b010;
    core_cmd_ready = 1'b1;
    tick();
    settle();
    chk("rd_issue", {core_cmd_valid, req_ready, grant_id, core_cmd_type, core_cmd_addr},
        {1'b1, 3'b010, 2'd1, 3'd4, 24'h000123});
    tick();
    req_valid = '0;
    for (int i = 1; i <= 6; i++) begin
      settle();
      chk($sformatf("rd_wait%0d", i), {core_cmd_valid, req_ready, req_rsp_valid, arb_busy},
          {1'b0, 3'b000, 3'b000, 1'b1});
      tick();
    end
    core_rsp_valid = 1'b1;
    core_rsp_data  = 8'h5A;
    settle();
    chk("rd_rsp_not_yet", req_rsp_valid, 3'b000);
    tick();
    core_rsp_valid = 1'b0;
    settle();
    chk("rd_rsp", {req_rsp_valid, req_rsp_data, req_rsp_err, arb_busy}, {3'b010, 8'h5A, 1'b0, 1'b0});
    tick();
    settle();
    chk("rd_rsp_pulse_width", req_rsp_valid, 3'b000);
    core_rsp_valid = 1'b1;
    core_rsp_data  = 8'h33;
    tick();
    core_rsp_valid = 1'b0;
    settle();
    chk("stray_rsp_ignored", {req_rsp_valid, req_rsp_data, arb_busy}, {3'b000, 8'h5A, 1'b0});

    // Requester 1 locks for a 4-write burst while requester 0 waits
    req_type  = {3'd1, 3'd1, 3'd1};
    req_valid = 3'b010;
    req_lock  = 3'b010;
    tick();
    req_valid = 3'b011;
    hs0 = 0;
    hs1 = 0;
    c   = 0;
    while (hs1 < 4 && c < 20) begin
      settle();
      if (req_ready[1]) hs1++;
      if (req_ready[0]) hs0++;
      if (hs1 < 4) begin
        tick();
        c++;
      end
    end
    chk("lock_hs_count", hs1, 4);
    chk("lock_cycles", c, 6);
    chk("lock_no_req0", hs0, 0);
    tick();
    req_valid = 3'b001;
    settle();
    chk("lock_hold1", {core_cmd_valid, req_ready, grant_id, arb_busy}, {1'b0, 3'b000, 2'd1, 1'b1});
    tick();
    req_lock = 3'b000;
    settle();
    chk("lock_hold2", {core_cmd_valid, req_ready, grant_id, arb_busy}, {1'b0, 3'b000, 2'd1, 1'b1});
    tick();
    settle();
    chk("lock_release_idle", {core_cmd_valid, req_ready, grant_id, arb_busy}, {1'b0, 3'b000, 2'd1, 1'b0});
    tick();
    settle();
    chk("lock_req0_granted", {core_cmd_valid, req_ready, grant_id, arb_busy}, {1'b1, 3'b001, 2'd0, 1'b1});
    tick();
    req_valid = '0;

    // Read from requester 2 with no core response
    req_type  = {3'd4, 3'd1, 3'd1};
    req_valid = 3'b100;
    tick();
    settle();
    chk("to_issue", {core_cmd_valid, req_ready, grant_id}, {1'b1, 3'b100, 2'd2});
    tick();
    req_valid = '0;
    k = 1;
    settle();
    while (req_rsp_valid == 3'b000 && k < 1100) begin
      tick();
      settle();
      k++;
    end
    chk("to_latency", k, RSP_TIMEOUT);
    chk("to_rsp", {req_rsp_valid, req_rsp_data, req_rsp_err, timeout_err, arb_busy},
        {3'b100, 8'hEE, 1'b1, 1'b1, 1'b0});
    tick();
    settle();
    chk("to_sticky", {req_rsp_valid, timeout_err}, {3'b000, 1'b1});
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    settle();
    chk("to_clear", timeout_err, 1'b0);

    // core_cmd_ready held low for 20 cycles
    req_type       = {3'd1, 3'd1, 3'd1};
    req_valid      = 3'b001;
    core_cmd_ready = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      settle();
      chk($sformatf("stall%0d", i),
          {core_cmd_valid, req_ready, grant_id, core_cmd_type, core_cmd_addr, core_cmd_data},
          {1'b1, 3'b000, 2'd0, 3'd1, 24'h000010, 8'hA0});
      tick();
    end
    core_cmd_ready = 1'b1;
    settle();
    chk("stall_release", req_ready, 3'b001);
    tick();
    req_valid = '0;

    // Reset while waiting for a read response
    req_type  = {3'd1, 3'd4, 3'd1};
    req_valid = 3'b010;
    tick();
    tick();
    req_valid = '0;
    tick();
    tick();
    settle();
    chk("rst_pre_wait", {arb_busy, grant_id}, {1'b1, 2'd1});
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    settle();
    chk("rst_state", {arb_busy, grant_id, core_cmd_valid}, {1'b0, 2'd0, 1'b0});
    core_rsp_valid = 1'b1;
    core_rsp_data  = 8'h77;
    tick();
    core_rsp_valid = 1'b0;
    settle();
    chk("rst_late_rsp", {req_rsp_valid, req_rsp_data, req_rsp_err, arb_busy},
        {3'b000, 8'h00, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
